// File: rtl/branch_train_queue.sv
// -----------------------------------------------------------------------------
// branch_train_queue
//
// In-flight branch tracker that sits between a gshare predictor's predict port
// and its train port. Every issued prediction is captured at the tail (pc,
// predicted direction, history snapshot). Resolutions may arrive out of order,
// addressed by the tag handed out at allocation. Entries retire in program
// order from the head, one per cycle, producing a one-cycle training pulse.
// Retiring a mispredicted branch flushes every younger (wrong-path) entry.
//
// Optional feature (macro BTQ_RESOLVE_BYPASS_EN):
//   When defined, a resolve that targets the unresolved head entry retires it
//   at the same edge, using resolve_taken directly (1-cycle latency). When
//   undefined, resolve-to-train latency is 2 cycles and there is no
//   combinational path from resolve_* to train_*.
//
// Ports:
//   clk                 rising-edge clock
//   areset              synchronous, active-high reset
//   alloc_valid         prediction issued this cycle
//   alloc_pc            pc of the predicted branch
//   alloc_taken         predicted direction
//   alloc_history       history used for the prediction
//   alloc_ready         queue can accept an allocation (0 while areset)
//   alloc_tag           slot index given to this cycle's allocation (tail)
//   resolve_valid       branch outcome known
//   resolve_tag         slot being resolved
//   resolve_taken       actual direction
//   train_valid         one-cycle training pulse
//   train_taken         actual direction of the retired branch
//   train_mispredicted  actual direction differs from predicted direction
//   train_history       stored history of the retired branch
//   train_pc            stored pc of the retired branch
//   count               number of occupied entries
// -----------------------------------------------------------------------------
module branch_train_queue #(
    parameter int  N     = 7,
    parameter int  DEPTH = 8,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          alloc_valid,
    input  logic [N-1:0]  alloc_pc,
    input  logic          alloc_taken,
    input  logic [N-1:0]  alloc_history,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          resolve_valid,
    input  logic [TW-1:0] resolve_tag,
    input  logic          resolve_taken,
    output logic          train_valid,
    output logic          train_taken,
    output logic          train_mispredicted,
    output logic [N-1:0]  train_history,
    output logic [N-1:0]  train_pc,
    output logic [TW:0]   count
);

    localparam logic [TW:0]   FULL_COUNT = (TW+1)'(DEPTH);
    localparam logic [TW-1:0] PTR_ONE    = TW'(1);

    // Control state (reset) and payload storage (not reset).
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] resolved_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] actual_q;
    logic [N-1:0]     pc_q   [DEPTH];
    logic [N-1:0]     hist_q [DEPTH];
    logic [TW-1:0]    head_q;
    logic [TW-1:0]    tail_q;
    logic [TW:0]      count_q;

    // Decoded per-cycle events.
    logic retire;
    logic retire_actual;
    logic flush;
    logic alloc_fire;
    logic resolve_accept;

    // No pass-through: a full queue refuses even when the head retires now.
    assign alloc_ready = (count_q != FULL_COUNT) && !areset;
    assign alloc_tag   = tail_q;
    assign count       = count_q;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        retire        = valid_q[head_q] && resolved_q[head_q];
        retire_actual = actual_q[head_q];
`ifdef BTQ_RESOLVE_BYPASS_EN
        // Same-edge retire of the head using the incoming outcome.
        if (resolve_valid && (resolve_tag == head_q) &&
            valid_q[head_q] && !resolved_q[head_q]) begin
            retire        = 1'b1;
            retire_actual = resolve_taken;
        end
`endif
        flush          = retire && (retire_actual != pred_q[head_q]);
        // Wrong-path traffic in the flush cycle is discarded.
        alloc_fire     = alloc_valid && alloc_ready && !flush;
        resolve_accept = resolve_valid && valid_q[resolve_tag] &&
                         !resolved_q[resolve_tag] && !flush;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk) begin
        if (areset) begin
            valid_q            <= '0;
            resolved_q         <= '0;
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            train_valid        <= 1'b0;
            train_taken        <= 1'b0;
            train_mispredicted <= 1'b0;
            train_history      <= '0;
            train_pc           <= '0;
        end else begin
            train_valid <= retire;
            if (retire) begin
                train_taken        <= retire_actual;
                train_mispredicted <= flush;
                train_history      <= hist_q[head_q];
                train_pc           <= pc_q[head_q];
            end

            if (flush) begin
                valid_q    <= '0;
                resolved_q <= '0;
                head_q     <= head_q + PTR_ONE;
                tail_q     <= head_q + PTR_ONE;
                count_q    <= '0;
            end else begin
                // Later assignments win: resolve, then retire, then alloc.
                // Retire and alloc never hit the same slot (that needs a full
                // queue, which blocks allocation).
                if (resolve_accept) begin
                    resolved_q[resolve_tag] <= 1'b1;
                end
                if (retire) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + PTR_ONE;
                end
                if (alloc_fire) begin
                    valid_q[tail_q]    <= 1'b1;
                    resolved_q[tail_q] <= 1'b0;
                    tail_q             <= tail_q + PTR_ONE;
                end
                case ({alloc_fire, retire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; an entry's fields are
    // only read while its valid/resolved bits say they were written.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]   <= alloc_pc;
            hist_q[tail_q] <= alloc_history;
            pred_q[tail_q] <= alloc_taken;
        end
        if (resolve_accept) begin
            actual_q[resolve_tag] <= resolve_taken;
        end
    end

endmodule

// File: tb/tb_branch_train_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_train_queue
//
// Directed self-checking bench for branch_train_queue (N=7, DEPTH=8). Inputs
// are driven 1 time unit after each rising edge; outputs are sampled at the
// same point, so every check sees the state registered by the preceding edge.
// Expected values are hand-computed; BTQ_RESOLVE_BYPASS_EN selects the
// 1-cycle or 2-cycle resolve-to-train timing.
// -----------------------------------------------------------------------------
module tb_branch_train_queue;

    localparam int N  = 7;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          areset;
    logic          alloc_valid;
    logic [N-1:0]  alloc_pc;
    logic          alloc_taken;
    logic [N-1:0]  alloc_history;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          resolve_valid;
    logic [TW-1:0] resolve_tag;
    logic          resolve_taken;
    logic          train_valid;
    logic          train_taken;
    logic          train_mispredicted;
    logic [N-1:0]  train_history;
    logic [N-1:0]  train_pc;
    logic [TW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_train_queue dut (
        .clk                (clk),
        .areset             (areset),
        .alloc_valid        (alloc_valid),
        .alloc_pc           (alloc_pc),
        .alloc_taken        (alloc_taken),
        .alloc_history      (alloc_history),
        .alloc_ready        (alloc_ready),
        .alloc_tag          (alloc_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .count              (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [N-1:0] pc, input logic [N-1:0] hist, input logic tk);
        alloc_valid   = 1'b1;
        alloc_pc      = pc;
        alloc_history = hist;
        alloc_taken   = tk;
        tick();
        alloc_valid   = 1'b0;
    endtask

    task automatic resolve(input logic [TW-1:0] tag, input logic tk);
        resolve_valid = 1'b1;
        resolve_tag   = tag;
        resolve_taken = tk;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic check_train(input string tag, input logic [N-1:0] pc, input logic [N-1:0] hist,
                               input logic tk, input logic misp);
        check({tag, "_valid"}, 32'(train_valid), 32'd1);
        check({tag, "_pc"},    32'(train_pc), 32'(pc));
        check({tag, "_hist"},  32'(train_history), 32'(hist));
        check({tag, "_taken"}, 32'(train_taken), 32'(tk));
        check({tag, "_misp"},  32'(train_mispredicted), 32'(misp));
    endtask

    initial begin
        areset        = 1'b1;
        alloc_valid   = 1'b0;
        alloc_pc      = '0;
        alloc_taken   = 1'b0;
        alloc_history = '0;
        resolve_valid = 1'b0;
        resolve_tag   = '0;
        resolve_taken = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_ready_low", 32'(alloc_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_train_valid", 32'(train_valid), 32'd0);
        check("rst_train_pc", 32'(train_pc), 32'd0);
        areset = 1'b0;
        #1;
        check("rst_ready_high", 32'(alloc_ready), 32'd1);
        check("rst_tag", 32'(alloc_tag), 32'd0);

        // ---- Single branch, correct prediction ----
        alloc(7'h12, 7'h05, 1'b1);
        check("t1_count_after_alloc", 32'(count), 32'd1);
        check("t1_tag_next", 32'(alloc_tag), 32'd1);
        resolve(3'd0, 1'b1);
`ifndef BTQ_RESOLVE_BYPASS_EN
        check("t1_no_early_train", 32'(train_valid), 32'd0);
        check("t1_count_pending", 32'(count), 32'd1);
        tick();
`endif
        check_train("t1_train", 7'h12, 7'h05, 1'b1, 1'b0);
        check("t1_count_empty", 32'(count), 32'd0);
        tick();
        check("t1_pulse_ends", 32'(train_valid), 32'd0);

        // ---- Out-of-order resolve, in-order retire ----
        do_reset();
        alloc(7'h20, 7'h31, 1'b0);
        alloc(7'h21, 7'h32, 1'b1);
        alloc(7'h22, 7'h33, 1'b0);
        resolve(3'd2, 1'b0);
        resolve(3'd1, 1'b1);
        check("t2_head_blocks", 32'(train_valid), 32'd0);
        check("t2_count3", 32'(count), 32'd3);
        resolve(3'd0, 1'b0);
`ifndef BTQ_RESOLVE_BYPASS_EN
        check("t2_no_early_train", 32'(train_valid), 32'd0);
        tick();
`endif
        check_train("t2_tag0", 7'h20, 7'h31, 1'b0, 1'b0);
        tick();
        check_train("t2_tag1", 7'h21, 7'h32, 1'b1, 1'b0);
        tick();
        check_train("t2_tag2", 7'h22, 7'h33, 1'b0, 1'b0);
        check("t2_count0", 32'(count), 32'd0);
        tick();
        check("t2_pulse_ends", 32'(train_valid), 32'd0);

        // ---- Full queue, drop, wrap-around ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_tag%0d", i), 32'(alloc_tag), 32'(i));
            alloc(7'(8'h40 + i), 7'(i), 1'b1);
        end
        check("t3_full_count", 32'(count), 32'd8);
        check("t3_full_ready", 32'(alloc_ready), 32'd0);
        alloc(7'h7f, 7'h7f, 1'b0);
        check("t3_drop_count", 32'(count), 32'd8);
        check("t3_drop_tag", 32'(alloc_tag), 32'd0);
        // Keep allocating while the head retires: no pass-through.
        alloc_valid   = 1'b1;
        alloc_pc      = 7'h7e;
        alloc_history = 7'h7e;
        alloc_taken   = 1'b0;
        resolve(3'd0, 1'b1);
`ifndef BTQ_RESOLVE_BYPASS_EN
        check("t3_ready_while_pending", 32'(alloc_ready), 32'd0);
        tick();
`endif
        alloc_valid = 1'b0;
        check_train("t3_retire", 7'h40, 7'h00, 1'b1, 1'b0);
        check("t3_count7", 32'(count), 32'd7);
        check("t3_ready_again", 32'(alloc_ready), 32'd1);
        check("t3_wrap_tag", 32'(alloc_tag), 32'd0);
        alloc(7'h55, 7'h15, 1'b1);
        check("t3_refill_count", 32'(count), 32'd8);
        check("t3_tail_wrapped", 32'(alloc_tag), 32'd1);

        // ---- Mispredict flush ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(7'(8'h60 + i), 7'(8'h10 + i), 1'b1);
        end
        resolve(3'd1, 1'b1);
        resolve(3'd2, 1'b1);
        resolve(3'd3, 1'b1);
        check("t4_count4", 32'(count), 32'd4);
        check("t4_head_blocks", 32'(train_valid), 32'd0);
`ifndef BTQ_RESOLVE_BYPASS_EN
        resolve(3'd0, 1'b0);
        check("t4_no_early_train", 32'(train_valid), 32'd0);
        // Wrong-path alloc and resolve in the flush cycle.
        resolve_valid = 1'b1;
        resolve_tag   = 3'd2;
        resolve_taken = 1'b0;
        alloc(7'h70, 7'h70, 1'b0);
        resolve_valid = 1'b0;
`else
        alloc_valid   = 1'b1;
        alloc_pc      = 7'h70;
        alloc_history = 7'h70;
        alloc_taken   = 1'b0;
        resolve(3'd0, 1'b0);
        alloc_valid   = 1'b0;
`endif
        check_train("t4_flush", 7'h60, 7'h10, 1'b0, 1'b1);
        check("t4_count_flushed", 32'(count), 32'd0);
        check("t4_tag_after_flush", 32'(alloc_tag), 32'd1);
        tick();
        check("t4_no_younger_1", 32'(train_valid), 32'd0);
        check("t4_count_still0", 32'(count), 32'd0);
        tick();
        check("t4_no_younger_2", 32'(train_valid), 32'd0);
        alloc(7'h71, 7'h22, 1'b0);
        check("t4_new_count", 32'(count), 32'd1);
        resolve(3'd1, 1'b0);
`ifndef BTQ_RESOLVE_BYPASS_EN
        tick();
`endif
        check_train("t4_new_path", 7'h71, 7'h22, 1'b0, 1'b0);

        // ---- Repeat resolve and resolve to unallocated tag ----
        do_reset();
        alloc(7'h0a, 7'h01, 1'b0);
        alloc(7'h0b, 7'h02, 1'b0);
        resolve(3'd1, 1'b1);
        resolve(3'd1, 1'b0);
        resolve(3'd5, 1'b1);
        check("t5_count2", 32'(count), 32'd2);
        check("t5_no_train", 32'(train_valid), 32'd0);
        resolve(3'd0, 1'b0);
`ifndef BTQ_RESOLVE_BYPASS_EN
        tick();
`endif
        check_train("t5_tag0", 7'h0a, 7'h01, 1'b0, 1'b0);
        tick();
        check_train("t5_first_wins", 7'h0b, 7'h02, 1'b1, 1'b1);
        check("t5_count0", 32'(count), 32'd0);
        tick();
        check("t5_unalloc_no_train", 32'(train_valid), 32'd0);
        check("t5_unalloc_count", 32'(count), 32'd0);

        // ---- Reset mid-operation ----
        do_reset();
        alloc(7'h33, 7'h03, 1'b1);
        alloc(7'h34, 7'h04, 1'b1);
        alloc(7'h35, 7'h05, 1'b1);
        resolve(3'd1, 1'b1);
        resolve(3'd2, 1'b1);
        check("t6_count3", 32'(count), 32'd3);
        areset = 1'b1;
        resolve(3'd0, 1'b1);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_train", 32'(train_valid), 32'd0);
        check("t6_rst_ready", 32'(alloc_ready), 32'd0);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_no_pulse%0d", i), 32'(train_valid), 32'd0);
        end
        check("t6_count_after", 32'(count), 32'd0);
        check("t6_tag_after", 32'(alloc_tag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_train_queue.md
Name: branch_train_queue

Overview:
- In-flight branch tracker between the gshare predictor's predict port and its train port.
- Captures every issued prediction (pc, predicted direction, history snapshot) and accepts branch resolutions out of order.
- Retires entries in program order and drives train_valid, train_taken, train_mispredicted, train_history and train_pc into the predictor.
- Flushes all younger, wrong-path entries when it retires a mispredicted branch.

Parameters:
- N, 7, width of pc and global history.
- DEPTH, 8, number of queue entries; a power of 2, minimum 2.
- TW, $clog2(DEPTH), tag width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  reset; synchronous, active-high.
- alloc_valid  in  1  prediction issued this cycle.
- alloc_pc  in  N  pc of the predicted branch.
- alloc_taken  in  1  predicted direction.
- alloc_history  in  N  history used for the prediction.
- alloc_ready  out  1  queue can accept an allocation.
- alloc_tag  out  TW  slot index given to this cycle's allocation (equals the tail pointer).
- resolve_valid  in  1  branch outcome known.
- resolve_tag  in  TW  slot being resolved.
- resolve_taken  in  1  actual direction.
- train_valid  out  1  one-cycle training pulse.
- train_taken  out  1  actual direction of the retired branch.
- train_mispredicted  out  1  actual direction != predicted direction.
- train_history  out  N  stored history of the retired branch.
- train_pc  out  N  stored pc of the retired branch.
- count  out  TW+1  number of occupied entries.

Behaviour:
- Per-entry state: valid, resolved, pc, hist, pred, actual. head and tail pointers wrap modulo DEPTH.
- Reset (areset high at an edge):
  - Clears all valid/resolved bits, head = tail = 0, count = 0.
  - All train_* outputs = 0.
  - alloc_ready forced 0 while areset is high.
  - Reset mid-operation discards all entries with no train pulse.
- alloc_ready = (count != DEPTH) && !areset.
  - No pass-through: a full queue refuses allocation even if an entry retires in the same cycle.
- Allocation:
  - On alloc_valid && alloc_ready: write the entry at tail with valid = 1, resolved = 0; tail++ at the edge.
  - alloc_valid while not ready: dropped silently.
- Resolution:
  - On resolve_valid with entry[resolve_tag] valid and not yet resolved: set resolved = 1 and actual = resolve_taken.
  - A resolve to an invalid entry is ignored.
  - A repeat resolve to an already-resolved entry is ignored (first resolve wins).
- Retire:
  - Each cycle, if entry[head] is valid and resolved (registered state), then at the edge:
    - train_valid <= 1; train_taken <= actual; train_mispredicted <= (actual != pred); train_history <= hist; train_pc <= pc.
    - head entry invalidated; head++.
  - Otherwise train_valid <= 0; other train_* fields hold their last values.
  - At most one retire per cycle.
- Latency: resolve sampled at edge E -> train_valid high in the cycle following edge E+1, i.e. 2 cycles.
- Mispredict flush: when the retiring entry is mispredicted, at the same edge:
  - Invalidate every entry; tail <= head+1 (new head); count <= 0.
  - An allocation in that same cycle is discarded (wrong path).
  - A resolve in that cycle to any entry is discarded.
- count:
  - Updated at each edge as +1 alloc, -1 retire, both together = no change.
  - Set to 0 on flush or reset.

Optional Feature:
- Macro BTQ_RESOLVE_BYPASS_EN.
- Defined:
  - If resolve_valid targets the current head entry (valid, unresolved) in cycle t, retire happens at the same edge using resolve_taken directly.
  - Latency drops to 1 cycle; flush rules apply identically.
  - A non-head resolve behaves as normal.
- Undefined: 2-cycle resolve-to-train latency as above; no combinational path from resolve_* to train_*.

Test Plan:
- Reset, then alloc pc=0x12, hist=0x05, taken=1 (tag 0); resolve tag 0 taken=1 -> two cycles later train_valid=1, train_pc=0x12, train_history=0x05, train_taken=1, train_mispredicted=0; count returns to 0.
- Alloc tags 0,1,2; resolve 2, then 1, then 0 (all correct) -> three consecutive train_valid pulses in order tag 0,1,2, starting 2 cycles after the tag-0 resolve.
- Fill 8 entries -> alloc_ready=0, count=8; a 9th alloc_valid is dropped; after head retires, alloc_ready=1 and the next alloc gets tag 0 (wrap-around).
- Alloc tags 0..3; resolve tag 0 pred=1 actual=0 -> train_mispredicted=1, train_taken=0; count=0; tags 1..3 never train; a same-cycle alloc is discarded; the next alloc gets tag 1.
- Resolve tag 0 twice with different directions -> first value trains; resolve to an unallocated tag -> no effect.
- With BTQ_RESOLVE_BYPASS_EN: alloc tag 0, resolve tag 0 -> train_valid in the very next cycle. Separately, assert areset mid-queue -> count=0, train_valid=0, no pulses.
